// File: rtl/tlb_miss_arbiter_pkg.sv
//------------------------------------------------------------------------------
// tlb_miss_arbiter_pkg : shared types and constants for the TLB miss arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tlb_miss_arbiter_pkg;

  localparam int VPN_W       = 20;
  // The TLB fill filter uses the same constant to recognise ifetch walks.
  localparam int RQID_IFETCH = 0;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_ISSUED  = 2'd2,
    SLOT_MERGED  = 2'd3
  } slot_state_t;

  typedef enum logic [1:0] {
    WK_IDLE  = 2'd0,
    WK_REQ   = 2'd1,
    WK_WAIT  = 2'd2,
    WK_DRAIN = 2'd3
  } walk_state_t;

endpackage

`default_nettype wire

// File: rtl/tlb_miss_arbiter_if.sv
//------------------------------------------------------------------------------
// tlb_miss_arbiter_if : request/result handshake between arbiter and page walker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tlb_miss_arbiter_if
  import tlb_miss_arbiter_pkg::*;
#(
  parameter int ID_W = 2
) ();

  logic             req_valid;
  logic [VPN_W-1:0] req_vpn;
  logic [ID_W-1:0]  req_id;
  logic             req_ready;
  logic             res_valid;
  logic [ID_W-1:0]  res_id;
  logic             busy;

  modport master (
    output req_valid, req_vpn, req_id,
    input  req_ready, res_valid, res_id, busy
  );

  modport slave (
    input  req_valid, req_vpn, req_id,
    output req_ready, res_valid, res_id, busy
  );

endinterface

`default_nettype wire

// File: rtl/tlb_miss_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// tlb_miss_arbiter_rr_arbiter : combinational round-robin pick starting at ptr
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tlb_miss_arbiter_rr_arbiter #(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = $clog2(NUM_RQ)
) (
  input  logic [NUM_RQ-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_RQ-1:0] grant,
  output logic              valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_RQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % NUM_RQ);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlb_miss_arbiter.sv
//------------------------------------------------------------------------------
// tlb_miss_arbiter : per-requester miss slots, data-side merging, one walker
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tlb_miss_arbiter
  import tlb_miss_arbiter_pkg::*;
#(
  parameter int NUM_RQ = 3,
  parameter int ID_W   = $clog2(NUM_RQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IN_clear,
  input  logic [NUM_RQ-1:0]       IN_missValid,
  input  logic [NUM_RQ*VPN_W-1:0] IN_missVpn,
  output logic [NUM_RQ-1:0]       OUT_slotBusy,
  output logic [NUM_RQ-1:0]       OUT_done,
  tlb_miss_arbiter_if.master      pw
);

  slot_state_t      slot_state     [NUM_RQ];
  slot_state_t      slot_state_nxt [NUM_RQ];
  logic [ID_W-1:0]  slot_link      [NUM_RQ];
  logic [ID_W-1:0]  slot_link_nxt  [NUM_RQ];
  logic [VPN_W-1:0] slot_vpn       [NUM_RQ];
  logic [VPN_W-1:0] slot_vpn_nxt   [NUM_RQ];

  walk_state_t      walk_state, walk_state_nxt;
  logic [ID_W-1:0]  cur_id, cur_id_nxt;
  logic [VPN_W-1:0] cur_vpn, cur_vpn_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [NUM_RQ-1:0] done_q, done_nxt;

  logic [NUM_RQ-1:0] pending;
  logic [NUM_RQ-1:0] grant;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_RQ-1:0] complete;
  logic [NUM_RQ-1:0] captured;
  logic              res_hit;
  logic              match;
  logic [ID_W-1:0]   match_idx;
  logic [VPN_W-1:0]  vpn_i;

  always_comb begin
    for (int i = 0; i < NUM_RQ; i++) begin
      pending[i]      = (slot_state[i] == SLOT_PENDING);
      OUT_slotBusy[i] = (slot_state[i] != SLOT_EMPTY);
    end
  end

  tlb_miss_arbiter_rr_arbiter #(
    .NUM_RQ (NUM_RQ),
    .ID_W   (ID_W)
  ) u_rr_arbiter (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_RQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  assign res_hit = (walk_state == WK_WAIT) && pw.res_valid && (pw.res_id == cur_id);

  always_comb begin
    complete = '0;
    for (int i = 0; i < NUM_RQ; i++) begin
      if (res_hit && ((ID_W'(i) == cur_id) ||
                      (slot_state[i] == SLOT_MERGED && slot_link[i] == cur_id)))
        complete[i] = 1'b1;
    end
  end

  always_comb begin
    walk_state_nxt = walk_state;
    cur_id_nxt     = cur_id;
    cur_vpn_nxt    = cur_vpn;
    rr_ptr_nxt     = rr_ptr;
    done_nxt       = '0;
    captured       = '0;
    match          = 1'b0;
    match_idx      = '0;
    vpn_i          = '0;
    for (int i = 0; i < NUM_RQ; i++) begin
      slot_state_nxt[i] = slot_state[i];
      slot_link_nxt[i]  = slot_link[i];
      slot_vpn_nxt[i]   = slot_vpn[i];
    end

    if (IN_clear) begin
      // Flushed slots never signal done; an accepted request must be drained.
      for (int i = 0; i < NUM_RQ; i++) slot_state_nxt[i] = SLOT_EMPTY;
      case (walk_state)
        WK_REQ:   walk_state_nxt = pw.req_ready ? WK_DRAIN : WK_IDLE;
        WK_WAIT:  walk_state_nxt = WK_DRAIN;
        WK_DRAIN: walk_state_nxt = WK_DRAIN;
        default:  walk_state_nxt = WK_IDLE;
      endcase
    end else begin
      case (walk_state)
        WK_IDLE: begin
          if (grant_valid) begin
            cur_id_nxt                = grant_idx;
            cur_vpn_nxt               = slot_vpn[grant_idx];
            slot_state_nxt[grant_idx] = SLOT_ISSUED;
            rr_ptr_nxt     = (grant_idx == ID_W'(NUM_RQ - 1)) ? '0 : grant_idx + 1'b1;
            walk_state_nxt = WK_REQ;
          end
        end
        WK_REQ:   if (pw.req_ready) walk_state_nxt = WK_WAIT;
        WK_WAIT:  if (res_hit) walk_state_nxt = WK_IDLE;
        WK_DRAIN: if (!pw.busy && !pw.res_valid) walk_state_nxt = WK_IDLE;
        default:  walk_state_nxt = WK_IDLE;
      endcase

      done_nxt = complete;
      for (int i = 0; i < NUM_RQ; i++) begin
        if (complete[i]) slot_state_nxt[i] = SLOT_EMPTY;
      end

      // A slot finishing this cycle is not a merge target; lower-index
      // captures of the same cycle are, so same-cycle duplicates share a walk.
      for (int i = 0; i < NUM_RQ; i++) begin
        if (IN_missValid[i] && slot_state[i] == SLOT_EMPTY) begin
          vpn_i     = IN_missVpn[i*VPN_W +: VPN_W];
          match     = 1'b0;
          match_idx = '0;
          if (i != RQID_IFETCH) begin
            for (int k = NUM_RQ - 1; k > RQID_IFETCH; k--) begin
              if (k != i &&
                  (((slot_state[k] == SLOT_PENDING || slot_state[k] == SLOT_ISSUED) &&
                    !complete[k] && slot_vpn[k] == vpn_i) ||
                   (k < i && captured[k] && slot_state_nxt[k] == SLOT_PENDING &&
                    slot_vpn_nxt[k] == vpn_i))) begin
                match     = 1'b1;
                match_idx = ID_W'(k);
              end
            end
          end
          captured[i]       = 1'b1;
          slot_vpn_nxt[i]   = vpn_i;
          slot_link_nxt[i]  = match_idx;
          slot_state_nxt[i] = match ? SLOT_MERGED : SLOT_PENDING;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      walk_state <= WK_IDLE;
      cur_id     <= '0;
      cur_vpn    <= '0;
      rr_ptr     <= '0;
      done_q     <= '0;
      for (int i = 0; i < NUM_RQ; i++) begin
        slot_state[i] <= SLOT_EMPTY;
        slot_link[i]  <= '0;
        slot_vpn[i]   <= '0;
      end
    end else begin
      walk_state <= walk_state_nxt;
      cur_id     <= cur_id_nxt;
      cur_vpn    <= cur_vpn_nxt;
      rr_ptr     <= rr_ptr_nxt;
      done_q     <= done_nxt;
      for (int i = 0; i < NUM_RQ; i++) begin
        slot_state[i] <= slot_state_nxt[i];
        slot_link[i]  <= slot_link_nxt[i];
        slot_vpn[i]   <= slot_vpn_nxt[i];
      end
    end
  end

  assign pw.req_valid = (walk_state == WK_REQ);
  assign pw.req_vpn   = cur_vpn;
  assign pw.req_id    = cur_id;
  assign OUT_done     = done_q;

endmodule

`default_nettype wire
